// File: rtl/snn_pkg.sv
// Shared types for the spiking-neuron datapath blocks.
package snn_pkg;

    localparam int DATA_W = 32;

    typedef logic signed [DATA_W-1:0] potential_t;

    typedef enum logic [2:0] {
        IDLE,
        READ,
        ISSUE,
        WRITE,
        DONE
    } pdu_state_t;

endpackage

// File: rtl/potential_decay_unit_leak_shifter.sv
// Shift-based membrane leak: v - (v >>> shift).
module leak_shifter #(
    parameter int W  = 32,
    parameter int SW = 5
) (
    input  logic signed [W-1:0]  potential,
    input  logic        [SW-1:0] shift,
    output logic signed [W-1:0]  decayed
);

    // Subtracting a same-sign fraction of v can never overflow.
    assign decayed = potential - (potential >>> shift);

endmodule

// File: rtl/potential_decay_unit.sv
// Membrane potential store with per-timestep leak sweep.
// Optional refractory suppression: define REFRACTORY_EN.
module potential_decay_unit #(
    parameter int NEURON_COUNT      = 16,
    parameter int ADDR_W            = 4,
    parameter int DATA_W            = 32,
    parameter int DECAY_SHIFT       = 3,
    parameter int REFRACTORY_PERIOD = 2
) (
    input  logic                    CLK,
    input  logic                    RESETN,
    input  logic                    timestep_start,
    output logic                    busy,
    output logic                    done,
    output logic [ADDR_W-1:0]       neuron_id,
    output logic [DATA_W-1:0]       decayed_potential,
    output logic                    acc_valid,
    input  logic                    acc_result_valid,
    input  logic [DATA_W-1:0]       potential_from_acc,
    input  logic                    spiked_in,
    output logic [NEURON_COUNT-1:0] spike_vector,
    input  logic                    init_we,
    input  logic [ADDR_W-1:0]       init_addr,
    input  logic [DATA_W-1:0]       init_data
);
    import snn_pkg::*;

    localparam int SW = $clog2(DATA_W);
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NEURON_COUNT - 1);

    pdu_state_t state_q, state_d;

    logic signed [DATA_W-1:0] mem [NEURON_COUNT];
    logic signed [DATA_W-1:0] leaked;
    logic [DATA_W-1:0]        res_pot;
    logic                     res_spk;
    logic                     in_refr;

    leak_shifter #(
        .W  (DATA_W),
        .SW (SW)
    ) u_leak (
        .potential (mem[neuron_id]),
        .shift     (SW'(DECAY_SHIFT)),
        .decayed   (leaked)
    );

`ifdef REFRACTORY_EN
    localparam int RW = $clog2(REFRACTORY_PERIOD + 1);

    logic [RW-1:0] refr_q [NEURON_COUNT];

    assign in_refr = (refr_q[neuron_id] != '0);

    always_ff @(posedge CLK) begin
        if (!RESETN) begin
            for (int i = 0; i < NEURON_COUNT; i++) refr_q[i] <= '0;
        end else if (state_q == READ && in_refr) begin
            refr_q[neuron_id] <= refr_q[neuron_id] - RW'(1);
        end else if (state_q == WRITE && res_spk) begin
            refr_q[neuron_id] <= RW'(REFRACTORY_PERIOD);
        end
    end
`else
    assign in_refr = 1'b0;
`endif

    assign acc_valid = (state_q == ISSUE);
    assign busy      = (state_q == READ) || (state_q == ISSUE) || (state_q == WRITE);
    assign done      = (state_q == DONE);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (timestep_start) state_d = READ;
            READ:    state_d = in_refr ? WRITE : ISSUE;
            ISSUE:   if (acc_result_valid) state_d = WRITE;
            WRITE:   state_d = (neuron_id == LAST) ? DONE : READ;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RESETN) state_q <= IDLE;
        else         state_q <= state_d;
    end

    always_ff @(posedge CLK) begin
        if (!RESETN) begin
            for (int i = 0; i < NEURON_COUNT; i++) mem[i] <= '0;
            spike_vector      <= '0;
            neuron_id         <= '0;
            decayed_potential <= '0;
            res_pot           <= '0;
            res_spk           <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    // Host write lands on the same edge the sweep starts.
                    if (init_we && int'(init_addr) < NEURON_COUNT)
                        mem[init_addr] <= init_data;
                    if (timestep_start) begin
                        neuron_id    <= '0;
                        spike_vector <= '0;
                    end
                end
                READ: begin
                    decayed_potential <= leaked;
                    if (in_refr) begin
                        res_pot <= '0;
                        res_spk <= 1'b0;
                    end
                end
                ISSUE: begin
                    if (acc_result_valid) begin
                        res_pot <= potential_from_acc;
                        res_spk <= spiked_in;
                    end
                end
                WRITE: begin
                    mem[neuron_id]          <= res_spk ? '0 : res_pot;
                    spike_vector[neuron_id] <= res_spk;
                    if (neuron_id != LAST) neuron_id <= neuron_id + ADDR_W'(1);
                end
                default: ;
            endcase
        end
    end

endmodule
